// File: rtl/branch_update_unit.sv
// branch_update_unit: branch-result intake, redirect/flush FSM and predictor update FIFO (BRANCH_STATS_EN adds counters)
module branch_update_unit #(
  parameter int WIDTH = 31,
  parameter int PHT_BITS = 8,
  parameter int DEPTH = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                request,
  output logic                branchReady,
  input  logic                isBranch,
  input  logic                takenBranch,
  input  logic                mispredict,
  input  logic                writeBTB,
  input  logic [1:0]          nextState,
  input  logic [PHT_BITS-1:0] phtIndex,
  input  logic [WIDTH:0]      fetchPC,
  input  logic [WIDTH:0]      correctAddress,
  output logic                fetchRedirect,
  output logic [WIDTH:0]      redirectPC,
  output logic                flush,
  input  logic                tableStall,
  output logic                phtWrite,
  output logic [PHT_BITS-1:0] phtWrIndex,
  output logic [1:0]          phtWrData,
  output logic                btbWrite,
  output logic [WIDTH:0]      btbWrPC,
  output logic [WIDTH:0]      btbWrTarget,
  output logic                btbWrValid,
  output logic [PHT_BITS-1:0] ghr
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         branchCount,
  output logic [31:0]         mispredictCount
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, REDIRECT, HOLD} state_t;
  typedef struct packed {
    logic                br;
    logic                tk;
    logic                wb;
    logic [1:0]          ns;
    logic [PHT_BITS-1:0] idx;
    logic [WIDTH:0]      pc;
    logic [WIDTH:0]      tgt;
  } entry_t;
  state_t state, state_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  entry_t mem [DEPTH];
  entry_t head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic accept, enq, deq;
  assign head = mem[rp];
  assign branchReady = (state == IDLE) && (count != (AW+1)'(DEPTH));
  assign accept = request && branchReady;
  assign enq = accept && (isBranch || writeBTB);
  assign deq = (count != '0) && !tableStall;
  assign fetchRedirect = state == REDIRECT;
  assign flush = state == REDIRECT;
  always_comb begin
    state_nx = state;
    hold_nx = hold_cnt;
    case (state)
      IDLE: state_nx = accept && mispredict ? REDIRECT : IDLE;
      REDIRECT: begin
        state_nx = HOLD;
        hold_nx = HW'(FLUSH_CYCLES - 1);
      end
      HOLD: begin
        state_nx = hold_cnt == '0 ? IDLE : HOLD;
        hold_nx = hold_cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (enq) mem[wp] <= {isBranch, takenBranch, writeBTB, nextState, phtIndex, fetchPC, correctAddress};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      ghr <= '0;
      redirectPC <= '0;
      phtWrite <= 1'b0;
      phtWrIndex <= '0;
      phtWrData <= '0;
      btbWrite <= 1'b0;
      btbWrPC <= '0;
      btbWrTarget <= '0;
      btbWrValid <= 1'b0;
    end else begin
      state <= state_nx;
      hold_cnt <= hold_nx;
      if (accept && mispredict) redirectPC <= correctAddress;
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
      phtWrite <= deq && head.br;
      btbWrite <= deq && head.wb;
      if (deq) begin
        phtWrIndex <= head.idx;
        phtWrData <= head.ns;
        btbWrPC <= head.pc;
        btbWrTarget <= head.tgt;
        btbWrValid <= head.tk;
        if (head.br) ghr <= {ghr[PHT_BITS-2:0], head.tk};
      end
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      branchCount <= '0;
      mispredictCount <= '0;
    end else begin
      if (accept && isBranch) branchCount <= branchCount + 32'd1;
      if (accept && mispredict) mispredictCount <= mispredictCount + 32'd1;
    end
  end
`endif
endmodule
